// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with anti-ghost blanking.
// Optional per-digit blinking is built in when SEG_BLINK_EN is defined.
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5*NUM_DIGITS-1:0] glyphs,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic [IDX_W-1:0]        scan_idx
);

  localparam int                REF_W      = $clog2(REFRESH_DIV);
  localparam logic [REF_W-1:0]  REF_LAST   = REF_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [4:0]        BLANK_CODE = 5'd18;
  localparam logic [6:0]        SEG_OFF    = 7'b1111111;

  logic [REF_W-1:0]      ref_cnt;
  logic [IDX_W-1:0]      idx;
  logic [4:0]            glyph_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] mask_q;
  logic                  blink_phase;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;

  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:    s = 7'b1000000;
      5'd1:    s = 7'b1111001;
      5'd2:    s = 7'b0100100;
      5'd3:    s = 7'b0110000;
      5'd4:    s = 7'b0011001;
      5'd5:    s = 7'b0010010;
      5'd6:    s = 7'b0000010;
      5'd7:    s = 7'b1111000;
      5'd8:    s = 7'b0000000;
      5'd9:    s = 7'b0010000;
      5'd10:   s = 7'b0001000;
      5'd11:   s = 7'b0001100;
      5'd12:   s = 7'b0001001;
      5'd13:   s = 7'b1000111;
      5'd14:   s = 7'b0000110;
      5'd15:   s = 7'b0100001;
      5'd16:   s = 7'b0111111;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

`ifdef SEG_BLINK_EN
  localparam int                BLINK_W    = $clog2(BLINK_DIV);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_cnt;

  // Free-running: the blink phase is deliberately not aligned to the scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      mask_q      <= '0;
    end else begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      if (load) mask_q <= blink_mask;
    end
  end
`else
  logic unused_blink;

  assign unused_blink = ^blink_mask;
  assign mask_q       = '0;
  assign blink_phase  = 1'b0;
`endif

  // ref_cnt == 0 is the anti-ghost slot: all anodes off while the digit changes.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    if (ref_cnt != '0) begin
      an_d[idx] = 1'b0;
      if (!(mask_q[idx] && blink_phase)) seg_d = decode(glyph_q[idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt  <= '0;
      idx      <= '0;
      an       <= '1;
      seg      <= SEG_OFF;
      scan_idx <= '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) glyph_q[i] <= BLANK_CODE;
    end else begin
      an       <= an_d;
      seg      <= seg_d;
      scan_idx <= idx;
      if (ref_cnt == REF_LAST) begin
        ref_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      if (load) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) glyph_q[i] <= glyphs[5*i +: 5];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: decode table, directed scan/load/reset
// sequences and randomized traffic against a time-indexed reference model.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BD = 8;
`ifdef SEG_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [19:0]   glyphs = '0;
  logic          load = 1'b0;
  logic [3:0]    blink_mask = '0;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic [1:0]    scan_idx;

  seg_scan_driver #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .BLINK_DIV  (BD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .glyphs    (glyphs),
    .load      (load),
    .blink_mask(blink_mask),
    .an        (an),
    .seg       (seg),
    .scan_idx  (scan_idx)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: output at the t-th edge after reset is a pure function of t.
  int          m_glyph [ND];
  logic [3:0]  m_mask;
  int          m_t;
  logic [12:0] exp_vec;

  typedef struct {
    logic [4:0] code;
    logic [6:0] seg;
  } dec_vec_t;
  dec_vec_t tbl [20];

  function automatic logic [6:0] ref_decode(input int c);
    case (c)
      0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;
      3: return 7'b0110000;   4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;   8: return 7'b0000000;
      9: return 7'b0010000;  10: return 7'b0001000;  11: return 7'b0001100;
     12: return 7'b0001001;  13: return 7'b1000111;  14: return 7'b0000110;
     15: return 7'b0100001;  16: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [19:0] pack(input int g3, input int g2, input int g1, input int g0);
    return {5'(g3), 5'(g2), 5'(g1), 5'(g0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step(input logic r, input logic ld, input logic [19:0] g, input logic [3:0] m);
    int   pos, d;
    bit   ph;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    if (r) begin
      exp_vec = {4'hF, 7'h7F, 2'd0};
      for (int i = 0; i < ND; i++) m_glyph[i] = 18;
      m_mask = '0;
      m_t    = 0;
    end else begin
      pos   = m_t % RD;
      d     = (m_t / RD) % ND;
      ph    = ((m_t / BD) % 2) == 1;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      if (pos != 0) begin
        e_an[d] = 1'b0;
        if (!(BLINK_ON && m_mask[d] && ph)) e_seg = ref_decode(m_glyph[d]);
      end
      exp_vec = {e_an, e_seg, 2'(d)};
      if (ld) begin
        for (int i = 0; i < ND; i++) m_glyph[i] = int'(g[5*i +: 5]);
        if (BLINK_ON) m_mask = m;
      end
      m_t++;
    end
  endtask

  // Drive at the falling edge, let one rising edge occur, compare 1 time unit later.
  task automatic tick(input logic r, input logic ld, input logic [19:0] g, input logic [3:0] m);
    rst = r; load = ld; glyphs = g; blink_mask = m;
    model_step(r, ld, g, m);
    @(posedge clk);
    #1;
    check("model", 32'({an, seg, scan_idx}), 32'(exp_vec));
    @(negedge clk);
  endtask

  logic [3:0] fr_an  [4];
  logic [6:0] fr_seg [4];
  logic [3:0] post_an [4];

  initial begin
    tbl[0]  = '{5'd0,  7'b1000000};  tbl[1]  = '{5'd1,  7'b1111001};
    tbl[2]  = '{5'd2,  7'b0100100};  tbl[3]  = '{5'd3,  7'b0110000};
    tbl[4]  = '{5'd4,  7'b0011001};  tbl[5]  = '{5'd5,  7'b0010010};
    tbl[6]  = '{5'd6,  7'b0000010};  tbl[7]  = '{5'd7,  7'b1111000};
    tbl[8]  = '{5'd8,  7'b0000000};  tbl[9]  = '{5'd9,  7'b0010000};
    tbl[10] = '{5'd10, 7'b0001000};  tbl[11] = '{5'd11, 7'b0001100};
    tbl[12] = '{5'd12, 7'b0001001};  tbl[13] = '{5'd13, 7'b1000111};
    tbl[14] = '{5'd14, 7'b0000110};  tbl[15] = '{5'd15, 7'b0100001};
    tbl[16] = '{5'd16, 7'b0111111};  tbl[17] = '{5'd17, 7'b1111111};
    tbl[18] = '{5'd18, 7'b1111111};  tbl[19] = '{5'd31, 7'b1111111};
    fr_an[0] = 4'b1110; fr_seg[0] = 7'b1111001;
    fr_an[1] = 4'b1101; fr_seg[1] = 7'b0001000;
    fr_an[2] = 4'b1011; fr_seg[2] = 7'b0100100;
    fr_an[3] = 4'b0111; fr_seg[3] = 7'b0001100;
    post_an[0] = 4'b1111; post_an[1] = 4'b1110; post_an[2] = 4'b1110; post_an[3] = 4'b1110;

    // Reset held 3 cycles, then the first digit frame shows blank code 18.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, '0, '0);
      check("reset_an", 32'(an), 32'hF);
      check("reset_seg", 32'(seg), 32'h7F);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 20'($urandom), 4'($urandom));
      check("post_reset_an", 32'(an), 32'(post_an[i]));
      check("post_reset_seg", 32'(seg), 32'h7F);
    end

    // Decode table: load code into digit 0 at t=0, read it at t=1.
    for (int r = 0; r < 20; r++) begin
      tick(1'b1, 1'b0, '0, '0);
      tick(1'b0, 1'b1, pack(7, 7, 7, int'(tbl[r].code)), '0);
      tick(1'b0, 1'b0, '0, '0);
      check("decode_an", 32'(an), 32'hE);
      check($sformatf("decode_%0d", tbl[r].code), 32'(seg), 32'(tbl[r].seg));
    end

    // Glyphs {11,2,10,1}: two full scans with unrelated, unloaded input churn.
    tick(1'b1, 1'b0, '0, '0);
    tick(1'b0, 1'b1, pack(11, 2, 10, 1), '0);
    for (int t = 1; t <= 32; t++) begin
      tick(1'b0, 1'b0, 20'($urandom), 4'($urandom));
      check("frame_an", 32'(an), (t % 4 == 0) ? 32'hF : 32'(fr_an[(t / 4) % 4]));
      check("frame_seg", 32'(seg), (t % 4 == 0) ? 32'h7F : 32'(fr_seg[(t / 4) % 4]));
      check("frame_idx", 32'(scan_idx), 32'((t / 4) % 4));
    end
    // t=33: digit0 driven, load 16 into it; visible from the next edge.
    tick(1'b0, 1'b1, pack(11, 2, 10, 16), '0);
    check("load_same_edge", 32'(seg), 32'b1111001);
    tick(1'b0, 1'b0, pack(1, 1, 1, 1), '0);
    check("load_next_edge_seg", 32'(seg), 32'b0111111);
    check("load_next_edge_an", 32'(an), 32'hE);
    tick(1'b0, 1'b0, pack(0, 0, 0, 0), '0);
    tick(1'b0, 1'b0, pack(0, 0, 0, 0), '0);
    check("blank_slot_an", 32'(an), 32'hF);
    tick(1'b0, 1'b0, pack(0, 0, 0, 0), '0);
    check("digit1_unchanged", 32'(seg), 32'b0001000);

    // Blink: mask digit0 (model-checked), then digit2 which lands in phase 1 at t=9.
    tick(1'b1, 1'b0, '0, '0);
    tick(1'b0, 1'b1, pack(5, 5, 5, 5), 4'b0001);
    for (int t = 1; t < 48; t++) tick(1'b0, 1'b0, '0, '0);
    tick(1'b1, 1'b0, '0, '0);
    tick(1'b0, 1'b1, pack(5, 5, 5, 5), 4'b0100);
    for (int t = 1; t <= 9; t++) tick(1'b0, 1'b0, '0, '0);
    check("blink_digit2_an", 32'(an), 32'b1011);
    check("blink_digit2_seg", 32'(seg), BLINK_ON ? 32'h7F : 32'b0010010);
    tick(1'b0, 1'b0, '0, '0);
    tick(1'b0, 1'b0, '0, '0);
    tick(1'b0, 1'b0, '0, '0);
    tick(1'b0, 1'b0, '0, '0);
    check("blink_digit3_seg", 32'(seg), 32'b0010010);

    // Mid-frame reset at idx=2, ref_cnt=2 together with load: rst wins.
    tick(1'b1, 1'b0, '0, '0);
    tick(1'b0, 1'b1, pack(8, 8, 8, 8), '0);
    for (int t = 1; t < 10; t++) tick(1'b0, 1'b0, '0, '0);
    check("pre_rst_idx", 32'(scan_idx), 32'd2);
    tick(1'b1, 1'b1, pack(3, 3, 3, 3), 4'hF);
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_idx", 32'(scan_idx), 32'd0);
    for (int t = 0; t < 16; t++) begin
      tick(1'b0, 1'b0, pack(3, 3, 3, 3), '0);
      check("midrst_shadow_blank", 32'(seg), 32'h7F);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++)
      tick(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
           20'($urandom), 4'($urandom));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
